// File: rtl/clock_pkg.sv
// Shared timing helpers and FSM encoding for buzzer blocks.
// Used by buzz_tone_gen, tone_div and the alarm/chime blocks.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  function automatic int half_cyc(input int clk_hz, input int tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

  function automatic int ms_cyc(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/buzz_tone_gen_tone_div.sv
// tone_div: clearable divide-by-HALF toggle generator.
// Ports: clk, rst_n, clr (sync clear), en (count), tone (square wave).
import clock_pkg::*;

module tone_div #(
  parameter int HALF = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tone
);

  localparam int W = cw(HALF);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (en) begin
      if (cnt == W'(HALF - 1)) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/buzz_tone_gen.sv
// buzz_tone_gen: beep-burst responder driving a piezo buzzer.
// Ports: clk, rst_n, req, beeps[4:0], abort -> buzz_out, cycle, busy, done.
import clock_pkg::*;

module buzz_tone_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TONE_HZ = 2000,
  parameter int BEEP_MS = 250,
  parameter int GAP_MS  = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [4:0] beeps,
  input  logic       abort,
  output logic       buzz_out,
  output logic       cycle,
  output logic       busy,
  output logic       done
);

  localparam int HALF    = half_cyc(CLK_HZ, TONE_HZ);
  localparam int ON_CYC  = ms_cyc(CLK_HZ, BEEP_MS);
  localparam int OFF_CYC = ms_cyc(CLK_HZ, GAP_MS);
  localparam int PMAX    = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int PW      = cw(PMAX);

  if (HALF < 1 || ON_CYC < 1 || OFF_CYC < 1) begin : g_bad_cfg
    $error("buzz_tone_gen: derived cycle counts must be >= 1");
  end

  state_t        state, nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [4:0]    rem, rem_nxt;
  logic          cycle_nxt, done_nxt;
  logic          tone;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pcnt  <= '0;
      rem   <= '0;
      cycle <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      pcnt  <= pcnt_nxt;
      rem   <= rem_nxt;
      cycle <= cycle_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    nxt       = state;
    pcnt_nxt  = pcnt;
    rem_nxt   = rem;
    cycle_nxt = 1'b0;
    done_nxt  = 1'b0;
    if (abort) begin
      nxt      = IDLE;
      pcnt_nxt = '0;
      rem_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (beeps != 5'd0) begin
              rem_nxt  = beeps;
              pcnt_nxt = '0;
              nxt      = ON;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        ON: begin
          if (pcnt == PW'(ON_CYC - 1)) begin
            pcnt_nxt = '0;
            nxt      = OFF;
          end else begin
            pcnt_nxt = pcnt + 1'b1;
          end
        end
        OFF: begin
          if (pcnt == PW'(OFF_CYC - 1)) begin
            pcnt_nxt  = '0;
            cycle_nxt = 1'b1;
            rem_nxt   = rem - 1'b1;
            if (rem == 5'd1) begin
              done_nxt = 1'b1;
              nxt      = IDLE;
            end else begin
              nxt = ON;
            end
          end else begin
            pcnt_nxt = pcnt + 1'b1;
          end
        end
        default: begin
          nxt      = IDLE;
          pcnt_nxt = '0;
          rem_nxt  = '0;
        end
      endcase
    end
  end

  // Divider held clear outside ON so every beep starts at phase 0.
  tone_div #(
    .HALF (HALF)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ON),
    .en    (state == ON),
    .tone  (tone)
  );

  assign buzz_out = tone & (state == ON);
  assign busy     = (state == ON) || (state == OFF);

endmodule

// File: tb/tb_buzz_tone_gen.sv
// Directed bench for buzz_tone_gen with HALF=5, ON=20, OFF=10.
// Checks waveform, strobes, abort, reset and beep-count bounds.
module tb_buzz_tone_gen;

  localparam int BIG = 100000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [4:0] beeps;
  logic       abort;
  logic       buzz_out;
  logic       cycle;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  buzz_tone_gen #(
    .CLK_HZ  (1000),
    .TONE_HZ (100),
    .BEEP_MS (20),
    .GAP_MS  (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .beeps    (beeps),
    .abort    (abort),
    .buzz_out (buzz_out),
    .cycle    (cycle),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zeros(input string tag);
    check({tag, ".buzz"}, 32'(buzz_out), 0);
    check({tag, ".cycle"}, 32'(cycle), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
  endtask

  // k = cycles since the edge that sampled req (ON entry).
  task automatic burst(input int n, input int len,
                       input int ab_k, input int rq_k,
                       input int rst_k,
                       input int x_cyc, input int x_done);
    int ncyc;
    int ndone;
    int endk;
    int p;
    int ez, ec, ed, eb;
    bit cut;
    ncyc  = 0;
    ndone = 0;
    cut   = 1'b0;
    endk  = (ab_k < n * 30) ? ab_k : n * 30;
    req   = 1'b1;
    beeps = n[4:0];
    tick();
    req = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (k > 0) begin
        abort = (k == ab_k);
        if (k == rq_k) begin
          req   = 1'b1;
          beeps = 5'd5;
        end
        tick();
        req   = 1'b0;
        abort = 1'b0;
      end
      p  = k % 30;
      eb = (k < endk) ? 1 : 0;
      ec = (k > 0 && p == 0 && k <= n * 30 && k < ab_k) ? 1 : 0;
      ed = (k == n * 30 && k < ab_k) ? 1 : 0;
      ez = (eb == 1 && p < 20 && ((p / 5) % 2) == 1) ? 1 : 0;
      check($sformatf("b%0d.busy@%0d", n, k), 32'(busy), eb);
      check($sformatf("b%0d.cycle@%0d", n, k), 32'(cycle), ec);
      check($sformatf("b%0d.done@%0d", n, k), 32'(done), ed);
      check($sformatf("b%0d.buzz@%0d", n, k), 32'(buzz_out), ez);
      if (cycle) ncyc++;
      if (done) ndone++;
      if (k == rst_k) begin
        rst_n = 1'b0;
        #2;
        zeros("rst_mid");
        cut = 1'b1;
        break;
      end
    end
    if (!cut) begin
      check($sformatf("b%0d.ncycle", n), ncyc, x_cyc);
      check($sformatf("b%0d.ndone", n), ndone, x_done);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    beeps = 5'd0;
    abort = 1'b0;
    #23;
    zeros("reset");
    tick();
    rst_n = 1'b1;
    tick();
    zeros("idle");

    burst(3, 100, BIG, BIG, BIG, 3, 1);

    req   = 1'b1;
    beeps = 5'd0;
    tick();
    req = 1'b0;
    check("b0.done", 32'(done), 1);
    check("b0.busy", 32'(busy), 0);
    check("b0.buzz", 32'(buzz_out), 0);
    check("b0.cycle", 32'(cycle), 0);
    tick();
    check("b0.done_off", 32'(done), 0);
    check("b0.busy_off", 32'(busy), 0);

    burst(2, 100, BIG, 40, BIG, 2, 1);

    burst(3, 80, 45, BIG, BIG, 1, 0);

    burst(3, 40, BIG, BIG, 25, 0, 0);
    tick();
    zeros("rst_hold");
    rst_n = 1'b1;
    tick();
    zeros("rst_rel");
    burst(1, 40, BIG, BIG, BIG, 1, 1);

    burst(31, 970, BIG, BIG, BIG, 31, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
